// File: rtl/f_deserializer.sv
// Serial-to-parallel collector for the f bit stream. Completed words are
// handed off on a valid/ready port, along with their popcount and a sticky drop flag.
module f_deserializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         bit_in,
  input  logic                         bit_valid,
  output logic [WIDTH-1:0]             word_out,
  output logic [$clog2(WIDTH+1)-1:0]   ones_cnt,
  output logic                         word_valid,
  input  logic                         word_ready,
  output logic                         overflow,
  input  logic                         clr_ovf
);

  localparam int CW = $clog2(WIDTH+1);
  localparam int BW = $clog2(WIDTH);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [BW-1:0]    bcnt;
  logic [CW-1:0]    run_ones, ones_nxt;
  logic             complete, load, drop;

  // The next shift value already contains the bit sampled on this edge,
  // so it can be loaded straight into word_out when the word completes.
  always_comb begin
    shreg_nxt = MSB_FIRST ? {shreg[WIDTH-2:0], bit_in} : {bit_in, shreg[WIDTH-1:1]};
    ones_nxt  = run_ones + CW'(bit_in);
    complete  = bit_valid && (bcnt == BW'(WIDTH-1));
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    drop      = 1'b0;
    case (state)
      EMPTY: begin
        if (complete) begin
          load      = 1'b1;
          state_nxt = FULL;
        end
      end
      FULL: begin
        if (complete) begin
          if (word_ready) load = 1'b1;
          else            drop = 1'b1;
        end else if (word_ready) begin
          state_nxt = EMPTY;
        end
      end
    endcase
  end

  assign word_valid = (state == FULL);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= EMPTY;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg    <= '0;
      bcnt     <= '0;
      run_ones <= '0;
      word_out <= '0;
      ones_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (bit_valid) begin
        shreg <= shreg_nxt;
        if (complete) begin
          bcnt     <= '0;
          run_ones <= '0;
        end else begin
          bcnt     <= bcnt + BW'(1);
          run_ones <= ones_nxt;
        end
      end
      if (load) begin
        word_out <= shreg_nxt;
        ones_cnt <= ones_nxt;
      end
      // A drop on the same edge as a clear leaves the flag set.
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_f_deserializer.sv
// Bench for f_deserializer: LSB-first and MSB-first instances share the stimulus
// and are checked every cycle against a queue-based word model plus literal expectations.
module tb_f_deserializer;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst, bit_in, bit_valid, word_ready, clr_ovf;

  logic [W-1:0] wo_l, wo_m;
  logic [2:0]   oc_l, oc_m;
  logic         wv_l, wv_m, ov_l, ov_m;

  int n_cmp = 0;
  int n_bad = 0;

  f_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
    .word_out(wo_l), .ones_cnt(oc_l), .word_valid(wv_l),
    .word_ready(word_ready), .overflow(ov_l), .clr_ovf(clr_ovf));

  f_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
    .word_out(wo_m), .ones_cnt(oc_m), .word_valid(wv_m),
    .word_ready(word_ready), .overflow(ov_m), .clr_ovf(clr_ovf));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: bits in arrival order; a word is formed once W of them exist.
  bit m_bits[$];
  int m_lsb, m_msb, m_ones;
  bit m_valid, m_ovf;

  function automatic void model_reset();
    m_bits.delete();
    m_lsb = 0; m_msb = 0; m_ones = 0;
    m_valid = 1'b0; m_ovf = 1'b0;
  endfunction

  initial model_reset();
  always @(negedge rst) model_reset();

  always @(posedge clk) begin
    if (!rst) begin
      model_reset();
    end else begin
      int wl, wm, pc;
      bit done;
      done = 1'b0;
      wl = 0; wm = 0; pc = 0;
      if (bit_valid) begin
        m_bits.push_back(bit_in);
        if (m_bits.size() == W) begin
          done = 1'b1;
          for (int i = 0; i < W; i++) begin
            if (m_bits[i]) begin
              wl += (1 << i);
              wm += (1 << (W - 1 - i));
              pc++;
            end
          end
          m_bits.delete();
        end
      end
      if (done) begin
        if (!m_valid || word_ready) begin
          m_lsb = wl; m_msb = wm; m_ones = pc; m_valid = 1'b1;
        end else begin
          m_ovf = 1'b1;
        end
      end else if (m_valid && word_ready) begin
        m_valid = 1'b0;
      end
      if (!(done && m_valid && !word_ready && m_ovf) && clr_ovf && !(done && !word_ready && m_valid))
        m_ovf = 1'b0;
    end
  end

  always @(negedge clk) begin
    check("lsb_word",  32'(wo_l), 32'(m_lsb));
    check("msb_word",  32'(wo_m), 32'(m_msb));
    check("lsb_ones",  32'(oc_l), 32'(m_ones));
    check("msb_ones",  32'(oc_m), 32'(m_ones));
    check("lsb_valid", 32'(wv_l), 32'(m_valid));
    check("msb_valid", 32'(wv_m), 32'(m_valid));
    check("lsb_ovf",   32'(ov_l), 32'(m_ovf));
    check("msb_ovf",   32'(ov_m), 32'(m_ovf));
  end

  task automatic cyc(input bit v, input bit b, input bit r, input bit c);
    bit_valid = v; bit_in = b; word_ready = r; clr_ovf = c;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; word_ready = 1'b0; clr_ovf = 1'b0;
    @(negedge clk); @(negedge clk);
    check("rst_valid", 32'(wv_l), 32'd0);
    check("rst_word",  32'(wo_l), 32'd0);
    check("rst_ovf",   32'(ov_l), 32'd0);
    rst = 1'b1;

    // 1,0,1,1 back to back, consumer ready
    cyc(1, 1, 1, 0); cyc(1, 0, 1, 0); cyc(1, 1, 1, 0);
    check("t1_notyet", 32'(wv_l), 32'd0);
    cyc(1, 1, 1, 0);
    check("t1_valid", 32'(wv_l), 32'd1);
    check("t1_lsb",   32'(wo_l), 32'hD);
    check("t1_msb",   32'(wo_m), 32'hB);
    check("t1_ones",  32'(oc_l), 32'd3);
    cyc(0, 0, 1, 0);
    check("t1_taken", 32'(wv_l), 32'd0);
    check("t1_hold",  32'(wo_l), 32'hD);

    // same stream with gaps; bit_in inverted on gap cycles
    cyc(1, 1, 0, 0); cyc(0, 0, 0, 0); cyc(1, 0, 0, 0); cyc(0, 1, 0, 0);
    cyc(1, 1, 0, 0); cyc(0, 0, 0, 0); cyc(1, 1, 0, 0);
    check("t2_valid", 32'(wv_m), 32'd1);
    check("t2_msb",   32'(wo_m), 32'hB);
    check("t2_lsb",   32'(wo_l), 32'hD);
    check("t2_ones",  32'(oc_m), 32'd3);
    cyc(0, 0, 1, 0);
    check("t2_taken", 32'(wv_m), 32'd0);

    // 1111 then 0000 with consumer stalled
    for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0);
    check("t3_w1",    32'(wo_l), 32'hF);
    check("t3_ones1", 32'(oc_l), 32'd4);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0);
    check("t3_ovf",   32'(ov_l), 32'd1);
    check("t3_held",  32'(wo_l), 32'hF);
    check("t3_vheld", 32'(wv_l), 32'd1);
    cyc(0, 0, 1, 0);
    check("t3_taken", 32'(wv_l), 32'd0);
    check("t3_ovfst", 32'(ov_l), 32'd1);
    cyc(0, 0, 0, 1);
    check("t3_clr",   32'(ov_l), 32'd0);

    // 0001 then 1000 with ready only on the second completion edge
    cyc(1, 0, 0, 0); cyc(1, 0, 0, 0); cyc(1, 0, 0, 0); cyc(1, 1, 0, 0);
    check("t4_w1",    32'(wo_l), 32'h8);
    cyc(1, 1, 0, 0); cyc(1, 0, 0, 0); cyc(1, 0, 0, 0); cyc(1, 0, 1, 0);
    check("t4_w2",    32'(wo_l), 32'h1);
    check("t4_w2m",   32'(wo_m), 32'h8);
    check("t4_valid", 32'(wv_l), 32'd1);
    check("t4_noovf", 32'(ov_l), 32'd0);
    cyc(0, 0, 1, 0);

    // drop and clear on the same edge: set wins
    cyc(1, 1, 0, 0); cyc(1, 1, 0, 0); cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
    cyc(1, 1, 0, 0); cyc(1, 0, 0, 0); cyc(1, 1, 0, 0); cyc(1, 0, 0, 1);
    check("t5_setwin", 32'(ov_l), 32'd1);
    check("t5_held",   32'(wo_l), 32'h3);
    cyc(0, 0, 0, 1);
    check("t5_clr",    32'(ov_l), 32'd0);
    cyc(0, 0, 1, 0);

    // reset mid-word while FULL and overflowed
    cyc(1, 1, 0, 0); cyc(1, 0, 0, 0); cyc(1, 0, 0, 0); cyc(1, 1, 0, 0);
    for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 0); cyc(1, 1, 0, 0);
    check("t6_full", 32'(wv_l), 32'd1);
    check("t6_ovf",  32'(ov_l), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("t6_rvalid", 32'(wv_l), 32'd0);
    check("t6_rword",  32'(wo_l), 32'd0);
    check("t6_rones",  32'(oc_l), 32'd0);
    check("t6_rovf",   32'(ov_l), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    cyc(1, 0, 1, 0); cyc(1, 1, 1, 0); cyc(1, 1, 1, 0); cyc(1, 0, 1, 0);
    check("t6_word", 32'(wo_l), 32'h6);
    check("t6_wm",   32'(wo_m), 32'h6);
    check("t6_ones", 32'(oc_l), 32'd2);
    check("t6_val",  32'(wv_l), 32'd1);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
